// File: rtl/dyn_sense_reader.sv
// Dynamic-cell sense reader: per-cell bit/charge/age model with a precharge/sense/restore read FSM.
// Latency: rd_ack is high in the (PRE_CYC+SENSE_CYC+2)th cycle after the rd_req sample edge.
// Backpressure: rd_req is dropped while busy=1; writes are always accepted. DYN_AUTO_REFRESH_EN adds idle refresh.
module dyn_sense_reader #(
    parameter int DEPTH      = 8,
    parameter int DECAY      = 50,
    parameter int PRE_CYC    = 2,
    parameter int SENSE_CYC  = 2,
    parameter int REF_MARGIN = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic                     wr_data,
    input  logic                     rd_req,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic                     rd_ack,
    output logic                     rd_data,
    output logic                     rd_charged,
    output logic                     busy
);
    localparam int AW   = $clog2(DEPTH);
    localparam int GW   = $clog2(DECAY + 1);
    localparam int CMAX = (PRE_CYC > SENSE_CYC) ? PRE_CYC : SENSE_CYC;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [GW-1:0] DECAY_V = GW'(DECAY);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_SENSE,
        S_RESTORE,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   addr_q;
    logic            cap_bit_q, cap_chg_q;
    logic            rd_data_q, rd_chg_q;
    logic            accept, capture, restore;

    logic [DEPTH-1:0] cell_bit_q;
    logic [DEPTH-1:0] cell_chg_q;
    logic [GW-1:0]    cell_age_q [DEPTH];

    logic            ref_now;
    logic [AW-1:0]   ref_addr;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        capture = 1'b0;
        restore = 1'b0;
        case (state_q)
            S_IDLE: begin
                // A pending refresh only fires with rd_req low, so a request in IDLE is always taken.
                if (rd_req) begin
                    accept  = 1'b1;
                    state_d = S_PRE;
                    cnt_d   = '0;
                end
            end
            S_PRE: begin
                if (cnt_q == CW'(PRE_CYC - 1)) begin
                    state_d = S_SENSE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_SENSE: begin
                if (cnt_q == CW'(SENSE_CYC - 1)) begin
                    capture = 1'b1;
                    state_d = S_RESTORE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RESTORE: begin
                restore = cap_chg_q;
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

`ifdef DYN_AUTO_REFRESH_EN
    localparam logic [GW-1:0] REF_TH = GW'(DECAY - REF_MARGIN);

    logic [AW-1:0] ref_ptr_q;
    logic          scan;

    assign scan     = (state_q == S_IDLE) && !rd_req;
    assign ref_now  = scan && cell_chg_q[ref_ptr_q] && (cell_age_q[ref_ptr_q] >= REF_TH);
    assign ref_addr = ref_ptr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ref_ptr_q <= '0;
        end else if (scan) begin
            ref_ptr_q <= ref_ptr_q + 1'b1;
        end
    end
`else
    assign ref_now  = 1'b0;
    assign ref_addr = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            cap_bit_q <= 1'b0;
            cap_chg_q <= 1'b0;
            rd_data_q <= 1'b0;
            rd_chg_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                addr_q <= rd_addr;
            end
            if (capture) begin
                cap_bit_q <= cell_bit_q[addr_q];
                cap_chg_q <= cell_chg_q[addr_q];
            end
            // Result registers change only as DONE is entered, so they hold between acks.
            if (state_q == S_RESTORE) begin
                rd_data_q <= cap_chg_q & cap_bit_q;
                rd_chg_q  <= cap_chg_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cell_bit_q <= '0;
            cell_chg_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                cell_age_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                // Priority: external write, then read restore, then refresh, then decay.
                if (wr_en && (wr_addr == AW'(i))) begin
                    cell_bit_q[i] <= wr_data;
                    cell_chg_q[i] <= 1'b1;
                    cell_age_q[i] <= '0;
                end else if (restore && (addr_q == AW'(i))) begin
                    cell_bit_q[i] <= cap_bit_q;
                    cell_chg_q[i] <= 1'b1;
                    cell_age_q[i] <= '0;
                end else if (ref_now && (ref_addr == AW'(i))) begin
                    cell_chg_q[i] <= 1'b1;
                    cell_age_q[i] <= '0;
                end else if (cell_chg_q[i]) begin
                    if (cell_age_q[i] == DECAY_V - 1'b1) begin
                        cell_chg_q[i] <= 1'b0;
                        cell_age_q[i] <= DECAY_V;
                    end else begin
                        cell_age_q[i] <= cell_age_q[i] + 1'b1;
                    end
                end
            end
        end
    end

    assign rd_ack     = (state_q == S_DONE);
    assign rd_data    = rd_data_q;
    assign rd_charged = rd_chg_q;
    assign busy       = (state_q != S_IDLE) || ref_now;

endmodule

// File: tb/tb_dyn_sense_reader.sv
// Directed bench for dyn_sense_reader: reads are scoreboarded (expectation queued at request, popped at rd_ack).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_dyn_sense_reader;
    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic       wr_data;
    logic       rd_req;
    logic [2:0] rd_addr;
    logic       rd_ack;
    logic       rd_data;
    logic       rd_charged;
    logic       busy;

    int errors    = 0;
    int checks    = 0;
    int ack_total = 0;
    logic [1:0] exp_q[$];

    dyn_sense_reader dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_req     (rd_req),
        .rd_addr    (rd_addr),
        .rd_ack     (rd_ack),
        .rd_data    (rd_data),
        .rd_charged (rd_charged),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rd_ack === 1'b1) ack_total++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    // Issue one read; optionally write (wa,wd) in cycle wk after the accept edge (cycles 1-2 PRE, 5 RESTORE).
    task automatic do_read(input logic [2:0] a, input logic ed, input logic ec,
                           input int wk, input logic [2:0] wa, input logic wd);
        logic [1:0] e;
        bit got;
        exp_q.push_back({ed, ec});
        rd_req  = 1'b1;
        rd_addr = a;
        @(negedge clk);
        rd_req = 1'b0;
        got = 1'b0;
        for (int k = 1; k <= 12 && !got; k++) begin
            wr_en   = (k == wk);
            wr_addr = wa;
            wr_data = wd;
            if (k == 1) chk("busy_during_read", busy, 1);
            if (rd_ack === 1'b1) begin
                got = 1'b1;
                chk("ack_latency", k, 6);
                e = exp_q.pop_front();
                chk("rd_data", rd_data, e[1]);
                chk("rd_charged", rd_charged, e[0]);
            end
            @(negedge clk);
        end
        wr_en = 1'b0;
        if (!got) begin
            chk("rd_ack_timeout", 0, 1);
            e = exp_q.pop_front();
        end
    endtask

    initial begin
        int acks;
        int first_ack;
        int last_ack;
        int snap;

        rst     = 1'b1;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = 1'b0;
        rd_req  = 1'b0;
        rd_addr = '0;
        repeat (3) @(negedge clk);
        chk("reset_rd_ack", rd_ack, 0);
        chk("reset_rd_data", rd_data, 0);
        chk("reset_rd_charged", rd_charged, 0);
        chk("reset_busy", busy, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_busy", busy, 0);

        // Fresh write, read shortly after
        wr(3'd3, 1'b1);
        repeat (4) @(negedge clk);
        do_read(3'd3, 1'b1, 1'b1, 0, 3'd0, 1'b0);
        chk("rd_data_hold", rd_data, 1);
        chk("ack_one_cycle", rd_ack, 0);
        chk("busy_after_done", busy, 0);

        // Write during PRECHARGE is seen by the read
        wr(3'd2, 1'b1);
        do_read(3'd2, 1'b0, 1'b1, 1, 3'd2, 1'b0);
        // Write during RESTORE beats the restore
        wr(3'd2, 1'b1);
        do_read(3'd2, 1'b1, 1'b1, 5, 3'd2, 1'b0);
        do_read(3'd2, 1'b0, 1'b1, 0, 3'd0, 1'b0);

        // Continuous rd_req: one ack per 7 cycles
        acks = 0;
        first_ack = 0;
        last_ack = 0;
        rd_req  = 1'b1;
        rd_addr = 3'd3;
        @(negedge clk);
        for (int k = 1; k <= 20; k++) begin
            if (rd_ack === 1'b1) begin
                acks++;
                if (acks == 1) first_ack = k;
                last_ack = k;
            end
            if (k == 3) chk("busy_held_req", busy, 1);
            if (k == 7) chk("idle_gap_busy", busy, 0);
            @(negedge clk);
        end
        rd_req = 1'b0;
        chk("stream_ack_count", acks, 3);
        chk("stream_first_ack", first_ack, 6);
        chk("stream_last_ack", last_ack, 20);
        repeat (8) @(negedge clk);

        // Long idle: decays without refresh, survives with it
        wr(3'd0, 1'b1);
        repeat (60) @(negedge clk);
`ifdef DYN_AUTO_REFRESH_EN
        do_read(3'd0, 1'b1, 1'b1, 0, 3'd0, 1'b0);
`else
        do_read(3'd0, 1'b0, 1'b0, 0, 3'd0, 1'b0);
`endif

        // Reset in SENSE aborts the read
        wr(3'd5, 1'b1);
        snap = ack_total;
        rd_req  = 1'b1;
        rd_addr = 3'd5;
        @(negedge clk);
        rd_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_rd_ack", rd_ack, 0);
        chk("abort_rd_charged", rd_charged, 0);
        repeat (8) @(negedge clk);
        chk("abort_no_ack", ack_total, snap);
        for (int c = 0; c < 8; c++) begin
            do_read(3'(c), 1'b0, 1'b0, 0, 3'd0, 1'b0);
        end
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dyn_sense_reader.md
DYN_SENSE_READER -- requirements
Module: dyn_sense_reader

Interface
REQ-001 Parameter DEPTH, default 8: number of dynamic storage cells; power of two, 2..64.
REQ-002 Parameter DECAY, default 50: charge retention in clock cycles after write/restore; 4..1023.
REQ-003 Parameter PRE_CYC, default 2: precharge phase length in cycles; >=1.
REQ-004 Parameter SENSE_CYC, default 2: sense phase length in cycles; >=1.
REQ-005 Parameter REF_MARGIN, default 8: auto-refresh threshold margin in cycles; 1..DECAY-2.
REQ-006 clk  in  1  single clock; all state updates on rising edge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 wr_en  in  1  writer gate: stores wr_data into cell wr_addr this edge.
REQ-009 wr_addr  in  log2(DEPTH)  write cell index.
REQ-010 wr_data  in  1  write bit.
REQ-011 rd_req  in  1  read request; sampled only while busy=0.
REQ-012 rd_addr  in  log2(DEPTH)  read cell index; captured with rd_req.
REQ-013 rd_ack  out  1  one-cycle pulse: rd_data/rd_charged valid.
REQ-014 rd_data  out  1  sensed bit; held until next rd_ack.
REQ-015 rd_charged  out  1  1 = cell held charge at sense; 0 = decayed, rd_data forced 0.
REQ-016 busy  out  1  1 when read FSM not IDLE or refresh in progress.

Function
REQ-017 Each cell SHALL hold bit, charged flag, age counter (saturating at DECAY).
REQ-018 Write or restore SHALL set bit, charged=1, age=0; otherwise a charged cell's age SHALL increment each cycle.
REQ-019 Charged SHALL clear on the edge where age would reach DECAY: exactly DECAY cycles of charge after the last write/restore edge; bit becomes don't-care.
REQ-020 Read FSM states IDLE, PRECHARGE, SENSE, RESTORE, DONE.
REQ-021 IDLE->PRECHARGE when rd_req=1 and busy=0; rd_addr latched on the same edge.
REQ-022 PRECHARGE SHALL last PRE_CYC cycles, then SENSE for SENSE_CYC cycles.
REQ-023 Cell bit and charged flag SHALL be captured on the last SENSE cycle edge.
REQ-024 RESTORE (1 cycle) SHALL rewrite the captured bit if captured charged=1; a decayed cell SHALL NOT be restored.
REQ-025 DONE (1 cycle) SHALL assert rd_ack; next state IDLE.
REQ-026 Latency from rd_req sample edge to rd_ack high: PRE_CYC+SENSE_CYC+2 cycles (6 at defaults).
REQ-027 Writes SHALL be accepted in every state; write to the cell under read before capture SHALL be visible to the read; write during RESTORE to the same cell SHALL win over restore.
REQ-028 rd_req while busy=1 SHALL be ignored (no queueing).
REQ-029 busy SHALL be 1 from the edge after rd_req acceptance through the DONE cycle.

Reset
REQ-030 rst=1 SHALL force FSM IDLE, all cells charged=0, bit=0, age=0.
REQ-031 Outputs after reset: rd_ack=0, rd_data=0, rd_charged=0, busy=0.
REQ-032 rst mid-read SHALL abort with no rd_ack and no restore.

Configuration
REQ-033 Macro DYN_AUTO_REFRESH_EN: when defined, an idle-time refresh engine SHALL exist; when undefined, no refresh logic and cells decay only per REQ-019.
REQ-034 With macro: in IDLE with rd_req=0, a round-robin pointer SHALL scan one cell per cycle; a charged cell with age >= DECAY-REF_MARGIN SHALL be restored in 1 cycle (busy=1 that cycle).
REQ-035 With macro: rd_req SHALL have priority over starting a refresh; refresh never preempts a read.

Verification
REQ-036 Reset, write cell 3 = 1, read cell 3 at age 5 -> rd_ack 6 cycles after request, rd_data=1, rd_charged=1.
REQ-037 Write cell 0 = 1, no access for 60 cycles, macro undefined -> read gives rd_charged=0, rd_data=0.
REQ-038 Same as REQ-037 with DYN_AUTO_REFRESH_EN -> rd_charged=1, rd_data=1.
REQ-039 Read cell 2 (holding 1); wr_en cell 2 = 0 during PRECHARGE -> rd_data=0; during RESTORE -> cell 2 later reads 0.
REQ-040 rd_req asserted every cycle -> exactly one rd_ack per 7 cycles; second request during busy ignored.
REQ-041 rst pulsed in SENSE -> no rd_ack, busy=0 next cycle, all cells read rd_charged=0.
